// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pkg
//  Description : Shared types and constants for the OTTER MCU fetch stage.
//                Defines the PC source select encoding, the fetch FSM state
//                encoding and the NOP instruction loaded into IR on reset.
//  Revision    : 1.0  initial release
// ============================================================================
package otter_pkg;

    // addi x0, x0, 0 -- canonical RISC-V NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Next-PC source select. Codes 6 and 7 are unused and mean "hold".
    typedef enum logic [2:0] {
        PC_SEL_PLUS4  = 3'd0,
        PC_SEL_JALR   = 3'd1,
        PC_SEL_BRANCH = 3'd2,
        PC_SEL_JAL    = 3'd3,
        PC_SEL_MTVEC  = 3'd4,
        PC_SEL_MEPC   = 3'd5
    } pc_sel_t;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_WAIT  = 2'd2,
        FETCH_DRAIN = 2'd3
    } fetch_state_t;

endpackage : otter_pkg
`default_nettype wire

// File: rtl/otter_pc_mux.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pc_mux
//  Description : Combinational next-PC select. Chooses one of the PC sources
//                according to the select code; unused codes return the
//                current PC so the register holds its value.
//  Ports       : i_pc_sel          - source select (pc_sel_t)
//                i_pc / i_pc_plus4 - current PC and PC+4
//                i_jalr_tgt .. i_mepc - jump / trap targets
//                o_next_pc         - selected next PC
//  Revision    : 1.0  initial release
// ============================================================================
module otter_pc_mux
    import otter_pkg::*;
(
    input  pc_sel_t     i_pc_sel,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_jalr_tgt,
    input  logic [31:0] i_branch_tgt,
    input  logic [31:0] i_jal_tgt,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic [31:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_pc;
        case (i_pc_sel)
            PC_SEL_PLUS4:  o_next_pc = i_pc_plus4;
            PC_SEL_JALR:   o_next_pc = i_jalr_tgt;
            PC_SEL_BRANCH: o_next_pc = i_branch_tgt;
            PC_SEL_JAL:    o_next_pc = i_jal_tgt;
            PC_SEL_MTVEC:  o_next_pc = i_mtvec;
            PC_SEL_MEPC:   o_next_pc = i_mepc;
            default:       o_next_pc = i_pc;
        endcase
    end

endmodule : otter_pc_mux
`default_nettype wire

// File: rtl/otter_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : otter_fetch_unit
//  Description : Instruction fetch stage of the multicycle OTTER MCU. Holds
//                the PC, issues one read per FETCH to a variable-latency
//                instruction memory and latches the returned word into IR.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                fetch / flush / pc_write / pc_sel - control-unit commands
//                jalr_tgt .. mepc        - PC sources
//                mem_rden / mem_addr     - read request to memory
//                mem_ready / mem_rvalid / mem_rdata - memory handshake
//                ir / ir_imm / ir_valid  - instruction register
//                pc / pc_plus4           - program counter
//                fetch_busy / fetch_fault - status
//  Revision    : 1.0  initial release
// ============================================================================
module otter_fetch_unit
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch,
    input  logic        flush,
    input  logic        pc_write,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] jalr_tgt,
    input  logic [31:0] branch_tgt,
    input  logic [31:0] jal_tgt,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        mem_rden,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [24:0] ir_imm,
    output logic        ir_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_busy,
    output logic        fetch_fault
);

    // Timeout fires at the edge that completes the TIMEOUT_CYCLES-th busy
    // cycle, i.e. when the counter already holds TIMEOUT_CYCLES-1.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic [31:0] r_mem_addr;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic        r_fault;
    logic [7:0]  r_cnt;

    logic        w_timeout;
    logic        w_fetch_go;     // accepted fetch: latch address, enter REQ
    logic        w_fault_set;    // misaligned fetch or request/response timeout
    logic        w_capture;      // response accepted into IR
    logic [31:0] w_next_pc;

    assign w_timeout = (r_cnt >= c_TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // Next-PC source select
    // ------------------------------------------------------------------
    otter_pc_mux u_pc_mux (
        .i_pc_sel     (pc_sel_t'(pc_sel)),
        .i_pc         (r_pc),
        .i_pc_plus4   (r_pc_plus4),
        .i_jalr_tgt   (jalr_tgt),
        .i_branch_tgt (branch_tgt),
        .i_jal_tgt    (jal_tgt),
        .i_mtvec      (mtvec),
        .i_mepc       (mepc),
        .o_next_pc    (w_next_pc)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and event decode
    // FLUSH outranks everything; a response or acceptance outranks a
    // timeout landing on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_fetch_go   = 1'b0;
        w_fault_set  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                if (!flush && fetch) begin
                    if (r_pc[1:0] == 2'b00) begin
                        w_fetch_go   = 1'b1;
                        w_state_next = FETCH_REQ;
                    end else begin
                        w_fault_set  = 1'b1;
                    end
                end
            end
            FETCH_REQ: begin
                if (flush) begin
                    w_state_next = FETCH_IDLE;
                end else if (mem_ready) begin
                    w_state_next = FETCH_WAIT;
                end else if (w_timeout) begin
                    w_fault_set  = 1'b1;
                    w_state_next = FETCH_IDLE;
                end
            end
            FETCH_WAIT: begin
                if (flush) begin
                    // A response arriving with the flush is dropped here;
                    // otherwise the one still outstanding must be drained.
                    w_state_next = mem_rvalid ? FETCH_IDLE : FETCH_DRAIN;
                end else if (mem_rvalid) begin
                    w_capture    = 1'b1;
                    w_state_next = FETCH_IDLE;
                end else if (w_timeout) begin
                    w_fault_set  = 1'b1;
                    w_state_next = FETCH_IDLE;
                end
            end
            FETCH_DRAIN: begin
                // Stale response or timeout both end the drain silently.
                if (mem_rvalid || w_timeout) begin
                    w_state_next = FETCH_IDLE;
                end
            end
            default: w_state_next = FETCH_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        mem_rden   = 1'b0;
        fetch_busy = 1'b0;
        case (r_state)
            FETCH_IDLE:  fetch_busy = 1'b0;
            FETCH_REQ: begin
                mem_rden   = 1'b1;
                fetch_busy = 1'b1;
            end
            FETCH_WAIT:  fetch_busy = 1'b1;
            FETCH_DRAIN: fetch_busy = 1'b1;
            default: begin
                mem_rden   = 1'b0;
                fetch_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Busy-cycle counter (saturating so it cannot wrap back under the limit)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_fetch_go) begin
            r_cnt <= 8'd0;
        end else if (r_state != FETCH_IDLE && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Program counter. PC+4 is kept as its own register so both outputs
    // come straight from flops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + 32'd4;
        end else if (pc_write) begin
            r_pc       <= w_next_pc;
            r_pc_plus4 <= w_next_pc + 32'd4;
        end
    end

    // ------------------------------------------------------------------
    // Fetch address: sampled from the pre-write PC, only when a fetch
    // is accepted, so a concurrent PC_WRITE never disturbs it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr <= RESET_PC;
        end else if (w_fetch_go) begin
            r_mem_addr <= r_pc;
        end
    end

    // ------------------------------------------------------------------
    // Instruction register and validity
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir       <= NOP_INSTR;
            r_ir_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_ir <= mem_rdata;
            end
            if (flush || w_fetch_go) begin
                r_ir_valid <= 1'b0;
            end else if (w_capture) begin
                r_ir_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Single-cycle fault pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_set;
        end
    end

    assign mem_addr    = r_mem_addr;
    assign ir          = r_ir;
    assign ir_imm      = r_ir[31:7];
    assign ir_valid    = r_ir_valid;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc_plus4;
    assign fetch_fault = r_fault;

endmodule : otter_fetch_unit
`default_nettype wire

// File: doc/otter_fetch_unit.md
# otter_fetch_unit

Instruction fetch stage for the multicycle OTTER MCU. Holds the program counter, fetches one instruction per request from a variable-latency instruction memory, and latches it into the instruction register that drives the immediate generator and decoder. It is controlled by the control-unit FSM via FETCH, PC_WRITE and FLUSH.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- TIMEOUT_CYCLES, 255, cycles in REQ+WAIT before a bus fault (1..255)
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- FETCH  in  1  start a fetch at the current PC; honoured only in IDLE
- FLUSH  in  1  abort the in-flight fetch and invalidate IR
- PC_WRITE  in  1  load PC from the PC_SEL source
- PC_SEL  in  3  0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC, 6–7 hold
- JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC, MEPC  in  32 each  PC sources
- MEM_RDEN  out  1  read request, held until accepted
- MEM_ADDR  out  32  registered fetch address
- MEM_READY  in  1  memory accepts the request this cycle
- MEM_RVALID  in  1  read data valid
- MEM_RDATA  in  32  instruction word
- IR  out  32  instruction register
- IR_IMM  out  25  IR[31:7], the immediate-generator input
- IR_VALID  out  1  IR holds a fetched, unflushed instruction
- PC  out  32  current PC; PC_PLUS4  out  32  PC+4, wraps modulo 2^32
- FETCH_BUSY  out  1  state is not IDLE
- FETCH_FAULT  out  1  one-cycle pulse: misaligned PC or timeout

## Operation
- Reset values: PC=RESET_PC, MEM_ADDR=RESET_PC, IR=32'h0000_0013 (NOP), IR_VALID=0, FETCH_FAULT=0, state IDLE, timeout counter 0; MEM_RDEN=0.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: FETCH and PC[1:0]==0 → MEM_ADDR<=PC, IR_VALID<=0, counter cleared, → REQ. FETCH with PC[1:0]!=0 → FETCH_FAULT pulse, IR/IR_VALID unchanged, stay IDLE.
- REQ: MEM_RDEN=1. MEM_READY → WAIT. MEM_RVALID in REQ is ignored.
- WAIT: MEM_RVALID → IR<=MEM_RDATA, IR_VALID<=1, → IDLE.
- FLUSH: IR_VALID<=0 in any state. In REQ → IDLE (request withdrawn). In WAIT → DRAIN. In IDLE, FLUSH has priority over a same-cycle FETCH.
- DRAIN: the next MEM_RVALID is discarded, → IDLE. FETCH is ignored.
- Timeout: the counter increments each cycle in REQ/WAIT/DRAIN. On reaching TIMEOUT_CYCLES:
  - REQ/WAIT → FETCH_FAULT pulse, IR unchanged, → IDLE.
  - DRAIN → IDLE with no fault.
- FETCH outside IDLE is ignored. FETCH_BUSY tells the control unit not to issue it.
- PC_WRITE is honoured in any state. It never alters MEM_ADDR of an in-flight fetch.
- FETCH and PC_WRITE in the same cycle: the fetch uses the pre-write PC.
- PC_SEL 6–7: PC holds its value.
- Targets are loaded unmodified. Alignment is checked only at FETCH.

## Timing
- Zero-wait memory: FETCH at cycle 0 → REQ in cycle 1 (MEM_RDEN=1, MEM_READY=1) → WAIT in cycle 2 (MEM_RVALID=1) → IR and IR_VALID updated in cycle 3. Minimum latency is 3 cycles.
- MEM_RDEN and FETCH_BUSY decode combinationally from state. All other outputs are registered.
- The earliest response accepted is the cycle after acceptance.
- FETCH_FAULT is high for exactly one cycle, the cycle after the detecting edge.
- A reset mid-fetch returns to the reset values immediately. Any later MEM_RVALID in IDLE is ignored.

## Structure
- otter_pkg: pc_sel_t enum (PC_SEL_PLUS4…PC_SEL_MEPC), fetch_state_t enum, NOP_INSTR constant (32'h0000_0013).
- One sub-module: otter_pc_mux, a combinational next-PC select on pc_sel_t. The FSM, PC register and IR stay in otter_fetch_unit.

## Test plan
- Reset, then FETCH with a zero-wait memory returning 32'hFFF0_0093 → IR=32'hFFF0_0093 and IR_IMM=25'h1FFE001 at cycle 3, IR_VALID=1, MEM_ADDR=0.
- MEM_READY delayed 4 cycles and RVALID 3 cycles after that → MEM_RDEN held high for 5 cycles, IR updates on the 9th edge after FETCH.
- FLUSH in WAIT, then a stale RVALID of 32'hDEAD_BEEF, then a new FETCH → the stale word is discarded, IR_VALID=0 until the new fetch completes with its own data.
- PC_WRITE with PC_SEL=2 and BRANCH_TGT=32'h0000_0102, then FETCH → FETCH_FAULT pulse for one cycle, no MEM_RDEN. Then PC_SEL=0 with PC=32'hFFFF_FFFC → PC=0 (wrap).
- Memory never asserts MEM_READY, with TIMEOUT_CYCLES=8 → FETCH_FAULT after 8 REQ cycles, back to IDLE, IR unchanged.
- FETCH and PC_WRITE (PC_SEL=3, JAL_TGT=32'h40) in the same cycle at PC=32'h10 → MEM_ADDR=32'h10, PC=32'h40.
